kart_state_tx: RTL and testbench

//  Ethernet/RMII frame transmitter for the local kart state; it is the send-side counterpart of the receive path.
//  - On a request, latches player x/y/direction/game status/reset-flag.
//  - Builds one Ethernet II frame: preamble/SFD, MACs, ethertype, 46-byte payload, FCS.
//  - Drives eth_txd/eth_txen one dibit per eth_clk (50 MHz RMII).
//  - The 44-bit packing matches what the receiver unpacks into its 44-bit axiod word.

---
 rtl/kart_eth_pkg.sv | 46 ++++
 rtl/kart_state_tx_if.sv | 20 ++
 rtl/crc32_dibit.sv | 27 ++
 rtl/kart_state_tx.sv | 142 ++++++++++++++
 tb/tb_kart_state_tx.sv | 370 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kart_eth_pkg.sv
// Shared definitions for the kart-state Ethernet link: transmit FSM states,
// frame geometry and the 44-bit payload word layout used by both directions.
package kart_eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_SFD,
    ST_HDR,
    ST_PAY,
    ST_FCS,
    ST_IFG
  } tx_state_t;

  localparam int PRE_DIBITS = 31;
  localparam int HDR_BYTES  = 14;
  localparam int PAY_BYTES  = 46;
  localparam int FCS_DIBITS = 16;

  // Payload word bit positions; the receive unpacker reads the same fields.
  localparam int PAY_WORD_W     = 44;
  localparam int PAY_WORD_BYTES = 6;
  localparam int PAY_X_LSB      = 33;
  localparam int PAY_Y_LSB      = 21;
  localparam int PAY_DIR_LSB    = 11;
  localparam int PAY_GAME_LSB   = 5;
  localparam int PAY_RST_BIT    = 3;

  function automatic logic [PAY_WORD_W-1:0] pack_state(
    input logic [10:0] x,
    input logic [10:0] y,
    input logic [8:0]  dir,
    input logic [2:0]  game,
    input logic        rst
  );
    logic [PAY_WORD_W-1:0] p;
    p = '0;
    p[PAY_X_LSB +: 11]   = x;
    p[PAY_Y_LSB +: 11]   = y;
    p[PAY_DIR_LSB +: 9]  = dir;
    p[PAY_GAME_LSB +: 3] = game;
    p[PAY_RST_BIT]       = rst;
    return p;
  endfunction

endpackage

// File: rtl/kart_state_tx_if.sv
// Request bundle between the game logic (master) and the frame transmitter (slave).
interface kart_state_tx_if;
  logic        frame_req;
  logic [10:0] player_x;
  logic [10:0] player_y;
  logic [8:0]  direction;
  logic [2:0]  game_stat;
  logic        opp_reset;
  logic        busy;

  modport master (
    output frame_req, player_x, player_y, direction, game_stat, opp_reset,
    input  busy
  );

  modport slave (
    input  frame_req, player_x, player_y, direction, game_stat, opp_reset,
    output busy
  );
endinterface

// File: rtl/crc32_dibit.sv
// Ethernet CRC-32 (reflected 0xEDB88320) advanced by one RMII dibit per clock,
// bit 0 of the dibit processed first.
module crc32_dibit (
  input  logic        clk,
  input  logic        rst,
  input  logic        init,
  input  logic        en,
  input  logic [1:0]  din,
  output logic [31:0] crc
);

  localparam logic [31:0] POLY = 32'hEDB8_8320;

  function automatic logic [31:0] step(input logic [31:0] c, input logic b);
    return (c >> 1) ^ ((c[0] ^ b) ? POLY : 32'h0);
  endfunction

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst || init) begin
      crc <= '1;
    end else if (en) begin
      crc <= step(step(crc, din[0]), din[1]);
    end
  end

endmodule

// File: rtl/kart_state_tx.sv
// RMII transmitter: latches the local kart state on request and sends it as one
// Ethernet II frame (preamble, SFD, header, 46-byte payload, FCS) followed by the IFG.
import kart_eth_pkg::*;

module kart_state_tx #(
  parameter logic [47:0] DEST_MAC   = 48'hFFFF_FFFF_FFFF,
  parameter logic [47:0] SRC_MAC    = 48'h6969_5A06_5491,
  parameter logic [15:0] ETHERTYPE  = 16'h4B41,
  parameter int          IFG_DIBITS = 48
) (
  input  logic                  eth_clk,
  input  logic                  eth_rst,
  kart_state_tx_if.slave        req,
  output logic [1:0]            eth_txd,
  output logic                  eth_txen,
  output logic [15:0]           frames_sent,
  output logic [15:0]           frames_dropped
);

  localparam logic [111:0] HDR_WORD      = {DEST_MAC, SRC_MAC, ETHERTYPE};
  localparam logic [8:0]   PRE_LAST      = 9'(PRE_DIBITS - 1);
  localparam logic [8:0]   HDR_LAST      = 9'(HDR_BYTES * 4 - 1);
  localparam logic [8:0]   PAY_LAST      = 9'(PAY_BYTES * 4 - 1);
  localparam logic [8:0]   FCS_LAST      = 9'(FCS_DIBITS - 1);
  // The IDLE cycle that follows is the final idle dibit, so back-to-back gaps are IFG_DIBITS.
  localparam logic [8:0]   IFG_LAST      = 9'(IFG_DIBITS - 2);
  localparam logic [3:0]   HDR_LAST_BYTE = 4'(HDR_BYTES - 1);
  localparam logic [2:0]   PAY_LAST_BYTE = 3'(PAY_WORD_BYTES - 1);

  tx_state_t   state;
  logic [8:0]  cnt;
  logic [47:0] pay_q;
  logic [6:0]  byte_idx;
  logic [6:0]  hdr_bit;
  logic [5:0]  pay_bit;
  logic [7:0]  cur_byte;
  logic [1:0]  data_dibit;
  logic [1:0]  fcs_dibit;
  logic [1:0]  next_dibit;
  logic [31:0] crc;
  logic [31:0] fcs;

  crc32_dibit u_crc (
    .clk  (eth_clk),
    .rst  (eth_rst),
    .init (state == ST_SFD),
    .en   (state == ST_HDR || state == ST_PAY),
    .din  (data_dibit),
    .crc  (crc)
  );

  // Byte select: fields go MSB byte first, each byte LSB dibit first.
  assign byte_idx = cnt[8:2];
  assign hdr_bit  = {HDR_LAST_BYTE - byte_idx[3:0], 3'b000};
  assign pay_bit  = {PAY_LAST_BYTE - byte_idx[2:0], 3'b000};

  always_comb begin
    // NOTE: default assignment first so no path through the block infers a latch.
    cur_byte = 8'h00;
    if (state == ST_HDR) begin
      cur_byte = HDR_WORD[hdr_bit +: 8];
    end else if (state == ST_PAY && byte_idx < 7'(PAY_WORD_BYTES)) begin
      cur_byte = pay_q[pay_bit +: 8];
    end
  end

  assign data_dibit = cur_byte[{cnt[1:0], 1'b0} +: 2];
  assign fcs        = ~crc;
  assign fcs_dibit  = fcs[{cnt[3:0], 1'b0} +: 2];

  always_comb begin
    next_dibit = 2'b00;
    unique case (state)
      ST_PRE:         next_dibit = 2'b01;
      ST_SFD:         next_dibit = 2'b11;
      ST_HDR, ST_PAY: next_dibit = data_dibit;
      ST_FCS:         next_dibit = fcs_dibit;
      default:        next_dibit = 2'b00;
    endcase
  end

  always_ff @(posedge eth_clk) begin
    if (eth_rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      pay_q          <= '0;
      eth_txd        <= 2'b00;
      eth_txen       <= 1'b0;
      req.busy       <= 1'b0;
      frames_sent    <= '0;
      frames_dropped <= '0;
    end else begin
      eth_txd  <= next_dibit;
      eth_txen <= (state inside {ST_PRE, ST_SFD, ST_HDR, ST_PAY, ST_FCS});
      cnt      <= cnt + 1'b1;

      if (req.frame_req && state != ST_IDLE) begin
        frames_dropped <= frames_dropped + 1'b1;
      end

      unique case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (req.frame_req) begin
            pay_q    <= {4'h0, pack_state(req.player_x, req.player_y, req.direction,
                                          req.game_stat, req.opp_reset)};
            req.busy <= 1'b1;
            state    <= ST_PRE;
          end
        end
        ST_PRE: if (cnt == PRE_LAST) begin
          state <= ST_SFD;
          cnt   <= '0;
        end
        ST_SFD: begin
          state <= ST_HDR;
          cnt   <= '0;
        end
        ST_HDR: if (cnt == HDR_LAST) begin
          state <= ST_PAY;
          cnt   <= '0;
        end
        ST_PAY: if (cnt == PAY_LAST) begin
          state <= ST_FCS;
          cnt   <= '0;
        end
        ST_FCS: if (cnt == FCS_LAST) begin
          state       <= ST_IFG;
          cnt         <= '0;
          frames_sent <= frames_sent + 1'b1;
        end
        ST_IFG: if (cnt == IFG_LAST) begin
          state    <= ST_IDLE;
          cnt      <= '0;
          req.busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_kart_state_tx.sv
// Directed bench for kart_state_tx: a wire monitor reassembles RMII frames and
// each scenario task compares them against hand-computed bytes and a CRC-32 model.
module tb_kart_state_tx;

  logic        eth_clk = 1'b0;
  logic        eth_rst = 1'b1;
  logic [1:0]  eth_txd;
  logic        eth_txen;
  logic [15:0] frames_sent;
  logic [15:0] frames_dropped;

  int tests_run    = 0;
  int tests_failed = 0;

  kart_state_tx_if bus ();

  kart_state_tx dut (
    .eth_clk        (eth_clk),
    .eth_rst        (eth_rst),
    .req            (bus),
    .eth_txd        (eth_txd),
    .eth_txen       (eth_txen),
    .frames_sent    (frames_sent),
    .frames_dropped (frames_dropped)
  );

  always #10 eth_clk = ~eth_clk;

  // Wire monitor, sampled 1 time unit after each rising edge.
  logic [1:0] mon_d [0:299];
  int   mon_idx    = 0;
  int   mon_len    = 0;
  int   mon_frames = 0;
  int   mon_gap    = 0;
  int   low_run    = 0;
  logic prev_txen  = 1'b0;

  always @(posedge eth_clk) begin
    #1;
    if (eth_txen === 1'b1) begin
      if (!prev_txen) begin
        mon_gap = low_run;
        mon_idx = 0;
      end
      if (mon_idx < 300) mon_d[mon_idx] = eth_txd;
      mon_idx++;
      low_run = 0;
      prev_txen = 1'b1;
    end else begin
      if (prev_txen) begin
        mon_len = mon_idx;
        mon_frames++;
      end
      low_run++;
      prev_txen = 1'b0;
    end
  end

  // Byte k after the SFD (0 = first destination MAC byte).
  function automatic logic [7:0] mon_byte(input int k);
    return {mon_d[32+4*k+3], mon_d[32+4*k+2], mon_d[32+4*k+1], mon_d[32+4*k]};
  endfunction

  function automatic int pre_errors();
    int e = 0;
    for (int i = 0; i < 31; i++) if (mon_d[i] !== 2'b01) e++;
    if (mon_d[31] !== 2'b11) e++;
    return e;
  endfunction

  function automatic logic [111:0] mon_hdr();
    logic [111:0] h = '0;
    for (int k = 0; k < 14; k++) h = {h[103:0], mon_byte(k)};
    return h;
  endfunction

  function automatic logic [47:0] mon_pay6();
    logic [47:0] p = '0;
    for (int k = 14; k < 20; k++) p = {p[39:0], mon_byte(k)};
    return p;
  endfunction

  function automatic logic [7:0] mon_pad_or();
    logic [7:0] o = 8'h00;
    for (int k = 20; k < 60; k++) o = o | mon_byte(k);
    return o;
  endfunction

  function automatic logic [31:0] mon_fcs();
    return {mon_byte(63), mon_byte(62), mon_byte(61), mon_byte(60)};
  endfunction

  // Byte-serial reference CRC over the 60 header+payload bytes.
  function automatic logic [31:0] golden_fcs(input logic [47:0] pay6);
    logic [111:0] hdr;
    logic [31:0]  c;
    logic [7:0]   b;
    logic         fb;
    hdr = {48'hFFFF_FFFF_FFFF, 48'h6969_5A06_5491, 16'h4B41};
    c   = 32'hFFFF_FFFF;
    for (int k = 0; k < 60; k++) begin
      if (k < 14)      b = hdr[111-8*k -: 8];
      else if (k < 20) b = pay6[47-8*(k-14) -: 8];
      else             b = 8'h00;
      for (int i = 0; i < 8; i++) begin
        fb = c[0] ^ b[i];
        c  = c >> 1;
        if (fb) c = c ^ 32'hEDB8_8320;
      end
    end
    return ~c;
  endfunction

  task automatic set_state(input logic [10:0] x, input logic [10:0] y,
                           input logic [8:0] d, input logic [2:0] g, input logic r);
    bus.player_x  = x;
    bus.player_y  = y;
    bus.direction = d;
    bus.game_stat = g;
    bus.opp_reset = r;
  endtask

  // Returns on the falling edge right after the accepting rising edge.
  task automatic pulse_req();
    @(negedge eth_clk);
    bus.frame_req = 1'b1;
    @(negedge eth_clk);
    bus.frame_req = 1'b0;
  endtask

  task automatic wait_frames(input int target, input string name);
    int i = 0;
    while (mon_frames < target && i < 1000) begin
      @(negedge eth_clk);
      i++;
    end
    tests_run++;
    if (mon_frames < target) begin
      tests_failed++;
      $display("FAIL %s_timeout: frames seen %0d, required %0d", name, mon_frames, target);
    end
  endtask

  task automatic wait_idle(input string name);
    int i = 0;
    while (bus.busy !== 1'b0 && i < 600) begin
      @(negedge eth_clk);
      i++;
    end
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s_idle_timeout: busy %b, required 0", name, bus.busy);
    end
  endtask

  task automatic test_reset();
    bus.frame_req = 1'b1;
    set_state(11'd0, 11'd0, 9'd0, 3'd0, 1'b0);
    eth_rst = 1'b1;
    repeat (3) @(negedge eth_clk);
    tests_run++;
    if (eth_txd !== 2'b00) begin
      tests_failed++; $display("FAIL reset_txd: got %b, required 00", eth_txd);
    end
    tests_run++;
    if (eth_txen !== 1'b0) begin
      tests_failed++; $display("FAIL reset_txen: got %b, required 0", eth_txen);
    end
    tests_run++;
    if (bus.busy !== 1'b0) begin
      tests_failed++; $display("FAIL reset_busy: got %b, required 0", bus.busy);
    end
    tests_run++;
    if (frames_sent !== 16'd0 || frames_dropped !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_counters: sent %0d dropped %0d, required 0 0", frames_sent, frames_dropped);
    end
    eth_rst = 1'b0;
    bus.frame_req = 1'b0;
    @(negedge eth_clk);
    tests_run++;
    if (bus.busy !== 1'b0 || eth_txen !== 1'b0) begin
      tests_failed++;
      $display("FAIL req_during_reset: busy %b txen %b, required 0 0", bus.busy, eth_txen);
    end
  endtask

  task automatic test_basic_frame();
    int f0 = mon_frames;
    set_state(11'd100, 11'd200, 9'd270, 3'd1, 1'b0);
    pulse_req();
    tests_run++;
    if (bus.busy !== 1'b1 || eth_txen !== 1'b0) begin
      tests_failed++;
      $display("FAIL accept_edge: busy %b txen %b, required 1 0", bus.busy, eth_txen);
    end
    @(negedge eth_clk);
    tests_run++;
    if (eth_txen !== 1'b1 || eth_txd !== 2'b01) begin
      tests_failed++;
      $display("FAIL first_dibit: txen %b txd %b, required 1 01", eth_txen, eth_txd);
    end
    wait_frames(f0 + 1, "basic");
    tests_run++;
    if (mon_len !== 288) begin
      tests_failed++; $display("FAIL basic_len: got %0d, required 288", mon_len);
    end
    tests_run++;
    if (pre_errors() !== 0) begin
      tests_failed++; $display("FAIL basic_preamble: %0d bad dibits, required 0", pre_errors());
    end
    tests_run++;
    if (mon_hdr() !== {48'hFFFF_FFFF_FFFF, 48'h6969_5A06_5491, 16'h4B41}) begin
      tests_failed++; $display("FAIL basic_header: got %h", mon_hdr());
    end
    tests_run++;
    if (mon_pay6() !== 48'h00C8_1908_7020) begin
      tests_failed++; $display("FAIL basic_payload: got %h, required 00c819087020", mon_pay6());
    end
    tests_run++;
    if (mon_pad_or() !== 8'h00) begin
      tests_failed++; $display("FAIL basic_padding: OR of pad bytes %h, required 00", mon_pad_or());
    end
    tests_run++;
    if (mon_fcs() !== golden_fcs(48'h00C8_1908_7020)) begin
      tests_failed++;
      $display("FAIL basic_fcs: got %h, required %h", mon_fcs(), golden_fcs(48'h00C8_1908_7020));
    end
    tests_run++;
    if (frames_sent !== 16'd1 || bus.busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL basic_sent_ifg: sent %0d busy %b, required 1 1", frames_sent, bus.busy);
    end
    wait_idle("basic");
  endtask

  task automatic test_drop();
    int f0 = mon_frames;
    set_state(11'd2047, 11'd0, 9'd359, 3'd7, 1'b1);
    pulse_req();
    repeat (100) @(negedge eth_clk);
    pulse_req();
    wait_frames(f0 + 1, "drop");
    repeat (10) @(negedge eth_clk);
    tests_run++;
    if (bus.busy !== 1'b1 || eth_txen !== 1'b0) begin
      tests_failed++;
      $display("FAIL drop_in_ifg: busy %b txen %b, required 1 0", bus.busy, eth_txen);
    end
    pulse_req();
    tests_run++;
    if (frames_dropped !== 16'd2) begin
      tests_failed++; $display("FAIL drop_count: got %0d, required 2", frames_dropped);
    end
    tests_run++;
    if (mon_pay6() !== 48'h0FFE_000B_38E8 || mon_fcs() !== golden_fcs(48'h0FFE_000B_38E8)) begin
      tests_failed++;
      $display("FAIL drop_frame: payload %h fcs %h, required 0ffe000b38e8 %h",
               mon_pay6(), mon_fcs(), golden_fcs(48'h0FFE_000B_38E8));
    end
    wait_idle("drop");
    repeat (350) @(negedge eth_clk);
    tests_run++;
    if (mon_frames !== f0 + 1 || frames_sent !== 16'd2) begin
      tests_failed++;
      $display("FAIL drop_single_frame: frames on wire %0d sent %0d, required %0d 2",
               mon_frames - f0, frames_sent, 1);
    end
  endtask

  task automatic test_input_change();
    int f0 = mon_frames;
    set_state(11'd100, 11'd200, 9'd270, 3'd1, 1'b0);
    pulse_req();
    bus.player_x = 11'd7;
    wait_frames(f0 + 1, "latch");
    tests_run++;
    if (mon_pay6() !== 48'h00C8_1908_7020) begin
      tests_failed++; $display("FAIL latch_payload: got %h, required 00c819087020", mon_pay6());
    end
    tests_run++;
    if (mon_fcs() !== golden_fcs(48'h00C8_1908_7020) || frames_sent !== 16'd3) begin
      tests_failed++;
      $display("FAIL latch_fcs_sent: fcs %h sent %0d, required %h 3",
               mon_fcs(), frames_sent, golden_fcs(48'h00C8_1908_7020));
    end
    wait_idle("latch");
  endtask

  task automatic test_back_to_back();
    int f0 = mon_frames;
    set_state(11'd100, 11'd200, 9'd270, 3'd1, 1'b0);
    @(negedge eth_clk);
    bus.frame_req = 1'b1;
    wait_frames(f0 + 2, "b2b");
    tests_run++;
    if (mon_gap !== 48) begin
      tests_failed++; $display("FAIL b2b_gap: got %0d low cycles, required 48", mon_gap);
    end
    tests_run++;
    if (mon_len !== 288 || mon_fcs() !== golden_fcs(48'h00C8_1908_7020)) begin
      tests_failed++;
      $display("FAIL b2b_frame: len %0d fcs %h, required 288 %h",
               mon_len, mon_fcs(), golden_fcs(48'h00C8_1908_7020));
    end
    @(negedge eth_clk);
    bus.frame_req = 1'b0;
    wait_idle("b2b");
  endtask

  task automatic test_reset_mid_frame();
    int f0;
    set_state(11'd100, 11'd200, 9'd270, 3'd1, 1'b0);
    pulse_req();
    repeat (128) @(negedge eth_clk);
    eth_rst = 1'b1;
    @(negedge eth_clk);
    tests_run++;
    if (eth_txen !== 1'b0 || eth_txd !== 2'b00 || bus.busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL midrst_outputs: txen %b txd %b busy %b, required 0 00 0", eth_txen, eth_txd, bus.busy);
    end
    tests_run++;
    if (frames_sent !== 16'd0 || frames_dropped !== 16'd0) begin
      tests_failed++;
      $display("FAIL midrst_counters: sent %0d dropped %0d, required 0 0", frames_sent, frames_dropped);
    end
    eth_rst = 1'b0;
    repeat (2) @(negedge eth_clk);
    tests_run++;
    if (eth_txen !== 1'b0) begin
      tests_failed++; $display("FAIL midrst_no_resume: txen %b, required 0", eth_txen);
    end
    f0 = mon_frames;
    set_state(11'd5, 11'd3, 9'd1, 3'd2, 1'b1);
    pulse_req();
    wait_frames(f0 + 1, "midrst");
    tests_run++;
    if (mon_len !== 288 || pre_errors() !== 0) begin
      tests_failed++;
      $display("FAIL midrst_frame: len %0d bad preamble %0d, required 288 0", mon_len, pre_errors());
    end
    tests_run++;
    if (mon_pay6() !== 48'h000A_0060_0848 || mon_fcs() !== golden_fcs(48'h000A_0060_0848)) begin
      tests_failed++;
      $display("FAIL midrst_payload_fcs: payload %h fcs %h, required 000a00600848 %h",
               mon_pay6(), mon_fcs(), golden_fcs(48'h000A_0060_0848));
    end
    tests_run++;
    if (frames_sent !== 16'd1) begin
      tests_failed++; $display("FAIL midrst_sent: got %0d, required 1", frames_sent);
    end
    wait_idle("midrst");
  endtask

  initial begin
    bus.frame_req = 1'b0;
    set_state(11'd0, 11'd0, 9'd0, 3'd0, 1'b0);
    test_reset();
    test_basic_frame();
    test_drop();
    test_input_change();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
